mem_port_arbiter: RTL and testbench

//  Shares the single external memory port between the processor core
//  (instruction fetch, data read, data write) and a DMA/program-loader requester.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_rr.sv | 27 ++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the memory port arbiter.
//   State codes, owner codes, access kind codes, read-latency bounds and
//   the counter width used by the read-latency down-counter.
package mem_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_WAIT   = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   typedef logic [1:0] kind_t;

   localparam kind_t K_FETCH = 2'd0;
   localparam kind_t K_READ  = 2'd1;
   localparam kind_t K_WRITE = 2'd2;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 7;
   localparam int CNT_W      = 3;   // holds RD_LAT_MAX-1

   function automatic bit rd_lat_ok(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-input round-robin picker.
//   req_cpu, req_dma : pending requests
//   last_owner       : owner of the most recently completed access
//   grant_valid      : at least one request pending
//   grant_owner      : chosen owner (OWN_CPU / OWN_DMA)
// Purely combinational; the last_owner register lives in the parent.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic req_cpu,
   input  logic req_dma,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_owner
);

   always_comb begin
      grant_valid = req_cpu | req_dma;
      grant_owner = OWN_CPU;
      if (req_cpu && req_dma) begin
         grant_owner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (req_dma) begin
         grant_owner = OWN_DMA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between the CPU (fetch/read/write)
// and a DMA requester, sequencing address phase, read latency and completion.
//   clk_100, rst_n                 : clock, async active-low reset
//   cpu_fetch/read/write, cpu_addr, cpu_wdata -> cpu_rdata, cpu_wait
//   dma_req, dma_we, dma_addr, dma_wdata      -> dma_rdata, dma_done
//   mem_addr, mem_wdata, mem_we, mem_re <- mem_rdata : RAM port
//   err_multi                      : sticky, several cpu_* requests at once
//
// state  | meaning
// IDLE   | no access in flight; grant decided at the next edge
// ACCESS | one-cycle address phase, mem_we or mem_re strobed
// WAIT   | counting down the RAM read latency
// DONE   | completion cycle: dma_done or cpu_wait released
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
)
(
   input  logic              clk_100,
   input  logic              rst_n,
   input  logic              cpu_fetch,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_wait,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err_multi
);

   if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_check
      $error("mem_port_arbiter: RD_LAT must be within 1..7");
   end

   state_t            state;
   logic              owner_q;
   logic              last_owner;
   kind_t             kind_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;

   logic  cpu_any;
   logic  cpu_multi;
   kind_t cpu_kind;
   logic  grant_valid;
   logic  grant_owner;
   logic  in_access;
   logic  capture;

   assign cpu_any   = cpu_fetch | cpu_read | cpu_write;
   assign cpu_multi = (cpu_fetch & cpu_read) | (cpu_fetch & cpu_write) | (cpu_read & cpu_write);

   always_comb begin
      cpu_kind = K_FETCH;
      if (cpu_write) begin
         cpu_kind = K_WRITE;
      end else if (cpu_read) begin
         cpu_kind = K_READ;
      end
   end

   mem_arb_rr u_rr (
      .req_cpu     (cpu_any),
      .req_dma     (dma_req),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   assign in_access = (state == ST_ACCESS);

   // With RD_LAT=1 the data is taken at the end of the address phase itself.
   assign capture = (in_access && (kind_q != K_WRITE) && (RD_LAT == 1))
                  || ((state == ST_WAIT) && (cnt == '0));

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner_q    <= OWN_DMA;
         last_owner <= OWN_DMA;
         kind_q     <= K_FETCH;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt        <= '0;
         err_multi  <= 1'b0;
      end else begin
         if (cpu_multi) begin
            err_multi <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner_q <= grant_owner;
                  state   <= ST_ACCESS;
                  if (grant_owner == OWN_CPU) begin
                     kind_q  <= cpu_kind;
                     addr_q  <= cpu_addr;
                     wdata_q <= cpu_wdata;
                  end else begin
                     kind_q  <= dma_we ? K_WRITE : K_READ;
                     addr_q  <= dma_addr;
                     wdata_q <= dma_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               if (kind_q == K_WRITE || RD_LAT == 1) begin
                  state <= ST_DONE;
               end else begin
                  cnt   <= CNT_W'(RD_LAT - 1);
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               last_owner <= owner_q;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else if (capture) begin
         if (owner_q == OWN_CPU) begin
            cpu_rdata <= mem_rdata;
         end else begin
            dma_rdata <= mem_rdata;
         end
      end
   end

   // Address/data are only presented during the address phase so the RAM
   // port is quiet otherwise.
   assign mem_addr  = in_access ? addr_q : '0;
   assign mem_wdata = in_access ? wdata_q : '0;
   assign mem_we    = in_access && (kind_q == K_WRITE);
   assign mem_re    = in_access && (kind_q != K_WRITE);

   assign dma_done = (state == ST_DONE) && (owner_q == OWN_DMA);
   assign cpu_wait = cpu_any && !((state == ST_DONE) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: RAM model with RD_LAT pipeline, scoreboard
// of expected RAM accesses checked as the DUT strobes the port.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int LAT = 2;

   logic          clk_100 = 1'b0;
   logic          rst_n;
   logic          cpu_fetch, cpu_read, cpu_write;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_wait;
   logic          dma_req, dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic [DW-1:0] dma_rdata;
   logic          dma_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we, mem_re;
   logic [DW-1:0] mem_rdata;
   logic          err_multi;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk_100 = ~clk_100;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clk_100   (clk_100),
      .rst_n     (rst_n),
      .cpu_fetch (cpu_fetch),
      .cpu_read  (cpu_read),
      .cpu_write (cpu_write),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_wait  (cpu_wait),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_done  (dma_done),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .err_multi (err_multi)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      return DW'(i * 16'h0101) ^ 16'h1357;
   endfunction

   // RAM model: data appears LAT cycles after the mem_re cycle; 0xDEAD otherwise.
   logic [DW-1:0] ram     [0:255];
   logic [DW-1:0] rd_pipe [0:LAT-1];
   assign mem_rdata = rd_pipe[LAT-1];

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = init_val(i);
      ram[1] = 16'h1234;
      for (int i = 0; i < LAT; i++) rd_pipe[i] = 16'hDEAD;
      forever begin
         @(posedge clk_100);
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         rd_pipe[0] <= mem_re ? ram[mem_addr[7:0]] : 16'hDEAD;
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   logic [DW-1:0] exp_mem [0:255];

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   acc_t exp_q[$];
   acc_t mon_e;

   // Scoreboard: every RAM strobe must match the next expected access.
   always @(negedge clk_100) begin
      if (mem_we || mem_re) begin
         vectors++;
         if ((mem_we && mem_re) || u_dut.state !== ST_ACCESS) begin
            miscompares++;
            $display("FAIL strobe_excl: we=%b re=%b state=%0d, required one strobe in ACCESS",
                     mem_we, mem_re, u_dut.state);
         end
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: we=%b addr=%h, required no access", mem_we, mem_addr);
         end else begin
            mon_e = exp_q.pop_front();
            if (mem_we !== mon_e.we || mem_addr !== mon_e.addr ||
                (mon_e.we && mem_wdata !== mon_e.wdata)) begin
               miscompares++;
               $display("FAIL sb_access: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                        mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.addr, mon_e.wdata);
            end
         end
      end
   end

   task automatic push_exp(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_q.push_back({we, a, d});
      if (we) exp_mem[a[7:0]] = d;
   endtask

   task automatic idle_inputs();
      cpu_fetch = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
      cpu_addr  = '0;   cpu_wdata = '0;
      dma_req   = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
   endtask

   task automatic do_reset();
      @(posedge clk_100); #1;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk_100);
      #1 rst_n = 1'b1;
   endtask

   // Drives one CPU access, holds it until cpu_wait drops; scrambles the
   // address/data after the grant to show they are latched.
   task automatic cpu_xfer(input logic f, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic wait0, output int n_wait, output logic [DW-1:0] rd);
      @(posedge clk_100); #1;
      cpu_fetch = f; cpu_read = r; cpu_write = w; cpu_addr = a; cpu_wdata = d;
      #1 wait0 = cpu_wait;
      n_wait = 0;
      while (cpu_wait === 1'b1 && n_wait < 30) begin
         @(posedge clk_100); #1;
         n_wait++;
         cpu_addr  = AW'($urandom);
         cpu_wdata = DW'($urandom);
      end
      rd = cpu_rdata;
      cpu_fetch = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
   endtask

   task automatic dma_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit drop_early, output int n, output logic [DW-1:0] rd);
      @(posedge clk_100); #1;
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      n = 0;
      do begin
         @(posedge clk_100); #1;
         n++;
         if (drop_early) dma_req = 1'b0;
      end while (dma_done !== 1'b1 && n < 30);
      rd = dma_rdata;
      dma_req = 1'b0;
   endtask

   // Raises a CPU and a DMA request in the same cycle and holds each until served.
   task automatic run_tie(input logic c_fetch, input logic [AW-1:0] ca,
                          input logic d_we, input logic [AW-1:0] da, input logic [DW-1:0] dd_in,
                          output int cd, output int dd, output logic [DW-1:0] crd,
                          output logic [DW-1:0] drd);
      int c;
      @(posedge clk_100); #1;
      cpu_fetch = c_fetch; cpu_read = !c_fetch; cpu_addr = ca;
      dma_req = 1'b1; dma_we = d_we; dma_addr = da; dma_wdata = dd_in;
      c = 0; cd = -1; dd = -1; crd = '0; drd = '0;
      while ((cd < 0 || dd < 0) && c < 40) begin
         @(posedge clk_100); #1;
         c++;
         if (cd < 0 && cpu_wait === 1'b0) begin
            cd = c; crd = cpu_rdata;
            cpu_fetch = 1'b0; cpu_read = 1'b0;
         end
         if (dd < 0 && dma_done === 1'b1) begin
            dd = c; drd = dma_rdata;
            dma_req = 1'b0;
         end
      end
      cpu_fetch = 1'b0; cpu_read = 1'b0; dma_req = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk_100);
      #1;
      vectors++;
      if ({cpu_rdata, cpu_wait, dma_rdata, dma_done, mem_addr, mem_wdata, mem_we, mem_re, err_multi} !== '0
          || u_dut.state !== ST_IDLE) begin
         miscompares++;
         $display("FAIL reset_outputs: state=%0d cpu_rdata=%h dma_rdata=%h err=%b, required all 0",
                  u_dut.state, cpu_rdata, dma_rdata, err_multi);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_100); #1;
         vectors++;
         if ({cpu_rdata, cpu_wait, dma_rdata, dma_done, mem_addr, mem_wdata, mem_we, mem_re, err_multi} !== '0
             || u_dut.state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d: state=%0d we=%b re=%b, required IDLE and outputs 0",
                     i, u_dut.state, mem_we, mem_re);
         end
      end
   endtask

   task automatic test_write();
      logic w0; int n; logic [DW-1:0] rd;
      push_exp(1'b1, 16'h0010, 16'hBEEF);
      cpu_xfer(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, w0, n, rd);
      vectors++;
      if (w0 !== 1'b1) begin
         miscompares++;
         $display("FAIL write_wait_same_cycle: cpu_wait=%b, required 1", w0);
      end
      vectors++;
      if (n !== 2) begin
         miscompares++;
         $display("FAIL write_wait_len: high %0d cycles, required 2", n);
      end
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++;
         $display("FAIL write_rdata_hold: cpu_rdata=%h, required 0000", rd);
      end
      @(posedge clk_100); #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL write_pending: %0d accesses missing, required 0", exp_q.size());
      end
   endtask

   task automatic test_fetch();
      logic w0; int n; logic [DW-1:0] rd;
      push_exp(1'b0, 16'h0001, '0);
      cpu_xfer(1'b1, 1'b0, 1'b0, 16'h0001, 16'h7777, w0, n, rd);
      vectors++;
      if (w0 !== 1'b1 || n !== 4) begin
         miscompares++;
         $display("FAIL fetch_wait: first=%b high %0d cycles, required 1 and 4", w0, n);
      end
      vectors++;
      if (rd !== 16'h1234) begin
         miscompares++;
         $display("FAIL fetch_rdata: cpu_rdata=%h, required 1234", rd);
      end
      push_exp(1'b0, 16'h0010, '0);
      cpu_xfer(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, w0, n, rd);
      vectors++;
      if (rd !== exp_mem[8'h10]) begin
         miscompares++;
         $display("FAIL read_after_write: cpu_rdata=%h, required %h", rd, exp_mem[8'h10]);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL fetch_pending: %0d accesses missing, required 0", exp_q.size());
      end
   endtask

   task automatic test_arbitration();
      int cd, dd; logic [DW-1:0] crd, drd;
      logic w0; int n; logic [DW-1:0] rd;
      do_reset();
      // last_owner is DMA after reset: CPU read first, then DMA write.
      push_exp(1'b0, 16'h0020, '0);
      push_exp(1'b1, 16'h0030, 16'h5A5A);
      run_tie(1'b0, 16'h0020, 1'b1, 16'h0030, 16'h5A5A, cd, dd, crd, drd);
      vectors++;
      if (cd !== 4 || dd !== 7) begin
         miscompares++;
         $display("FAIL tie1_order: cpu done @%0d dma done @%0d, required 4 and 7", cd, dd);
      end
      vectors++;
      if (crd !== exp_mem[8'h20]) begin
         miscompares++;
         $display("FAIL tie1_cpu_rdata: %h, required %h", crd, exp_mem[8'h20]);
      end
      // DMA was last: CPU wins again; fetch sees the DMA write.
      push_exp(1'b0, 16'h0030, '0);
      push_exp(1'b0, 16'h0020, '0);
      run_tie(1'b1, 16'h0030, 1'b0, 16'h0020, 16'h0000, cd, dd, crd, drd);
      vectors++;
      if (cd !== 4 || dd !== 9) begin
         miscompares++;
         $display("FAIL tie2_order: cpu done @%0d dma done @%0d, required 4 and 9", cd, dd);
      end
      vectors++;
      if (crd !== 16'h5A5A || drd !== exp_mem[8'h20]) begin
         miscompares++;
         $display("FAIL tie2_rdata: cpu=%h dma=%h, required 5a5a and %h", crd, drd, exp_mem[8'h20]);
      end
      // After a lone CPU access the next tie goes to the DMA.
      push_exp(1'b0, 16'h0005, '0);
      cpu_xfer(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, w0, n, rd);
      push_exp(1'b1, 16'h0040, 16'h0F0F);
      push_exp(1'b0, 16'h0020, '0);
      run_tie(1'b0, 16'h0020, 1'b1, 16'h0040, 16'h0F0F, cd, dd, crd, drd);
      vectors++;
      if (dd !== 2 || cd !== 7) begin
         miscompares++;
         $display("FAIL tie3_order: dma done @%0d cpu done @%0d, required 2 and 7", dd, cd);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL arb_pending: %0d accesses missing, required 0", exp_q.size());
      end
   endtask

   task automatic test_multi_request();
      logic w0; int n; logic [DW-1:0] rd;
      vectors++;
      if (err_multi !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_pre: err_multi=%b, required 0", err_multi);
      end
      push_exp(1'b1, 16'h0050, 16'hC0DE);
      cpu_xfer(1'b0, 1'b1, 1'b1, 16'h0050, 16'hC0DE, w0, n, rd);
      vectors++;
      if (n !== 2 || err_multi !== 1'b1) begin
         miscompares++;
         $display("FAIL multi_write: wait %0d err=%b, required 2 and 1", n, err_multi);
      end
      push_exp(1'b0, 16'h0050, '0);
      cpu_xfer(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, w0, n, rd);
      vectors++;
      if (rd !== 16'hC0DE || err_multi !== 1'b1) begin
         miscompares++;
         $display("FAIL multi_sticky: rdata=%h err=%b, required c0de and 1", rd, err_multi);
      end
      do_reset();
      vectors++;
      if (err_multi !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_clear: err_multi=%b, required 0", err_multi);
      end
   endtask

   task automatic test_reset_mid_read();
      int n; logic [DW-1:0] rd; bit seen;
      // Request dropped right after the grant still completes.
      push_exp(1'b0, 16'h0060, '0);
      dma_xfer(1'b0, 16'h0060, 16'h0000, 1'b1, n, rd);
      vectors++;
      if (n !== 4 || rd !== exp_mem[8'h60]) begin
         miscompares++;
         $display("FAIL dma_read: done @%0d rdata=%h, required 4 and %h", n, rd, exp_mem[8'h60]);
      end
      @(posedge clk_100); #1;
      vectors++;
      if (dma_done !== 1'b0) begin
         miscompares++;
         $display("FAIL dma_done_pulse: dma_done=%b, required 0", dma_done);
      end
      push_exp(1'b0, 16'h0070, '0);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0070;
      repeat (2) @(posedge clk_100);
      #1;
      vectors++;
      if (u_dut.state !== ST_WAIT) begin
         miscompares++;
         $display("FAIL abort_setup: state=%0d, required %0d", u_dut.state, ST_WAIT);
      end
      rst_n = 1'b0;
      dma_req = 1'b0;
      #1;
      vectors++;
      if (dma_rdata !== '0 || dma_done !== 1'b0 || u_dut.state !== ST_IDLE) begin
         miscompares++;
         $display("FAIL abort_reset: dma_rdata=%h done=%b state=%0d, required 0 0 IDLE",
                  dma_rdata, dma_done, u_dut.state);
      end
      repeat (2) @(posedge clk_100);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_100); #1;
         if (dma_done !== 1'b0 || u_dut.state !== ST_IDLE || dma_rdata !== '0) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL abort_after: done/state/rdata disturbed after release, required quiet IDLE");
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL abort_pending: %0d accesses missing, required 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
      exp_mem[1] = 16'h1234;
      test_reset();
      test_write();
      test_fetch();
      test_arbitration();
      test_multi_request();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
